// File: rtl/dp_ram_be_if.sv
// One port of the byte-enable dual-port RAM: request fields plus the registered read result.
interface dp_ram_be_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic                  en;
  logic                  we;
  logic [DATA_W/8-1:0]   be;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W-1:0]     rdata;
  logic                  rvalid;

  modport master (
    output en, we, be, addr, wdata,
    input  rdata, rvalid
  );

  modport slave (
    input  en, we, be, addr, wdata,
    output rdata, rvalid
  );
endinterface

// File: rtl/dp_ram_be.sv
// True dual-port RAM with byte write enables, registered reads, deterministic
// cross-port collision handling and an optional post-reset clear sequencer.
module dp_ram_be #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 8,
  parameter int RDW_MODE     = 0,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic        clk,
  input  logic        rst,
  dp_ram_be_if.slave  a,
  dp_ram_be_if.slave  b,
  output logic        busy
);
  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   clrCnt_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                aRead, aWrite, bRead, bWrite, sameAddr;
  logic [DATA_W-1:0]   aRdata_d, bRdata_d;
  logic [DATA_W-1:0]   aRdata_q, bRdata_q;
  logic                aRvalid_q, bRvalid_q;

  always_comb begin
    aRead    = (state_q == IDLE) && a.en && !a.we;
    aWrite   = (state_q == IDLE) && a.en &&  a.we;
    bRead    = (state_q == IDLE) && b.en && !b.we;
    bWrite   = (state_q == IDLE) && b.en &&  b.we;
    sameAddr = (a.addr == b.addr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= (CLEAR_ON_RST != 0) ? CLEAR : IDLE;
      clrCnt_q <= '0;
    end else if (state_q == CLEAR) begin
      clrCnt_q <= clrCnt_q + 1'b1;
      if (clrCnt_q == '1) state_q <= IDLE;
    end
  end

  // A's byte writes are issued after B's so that A wins any shared byte.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem[clrCnt_q] <= '0;
      end else begin
        for (int i = 0; i < NB; i++) begin
          if (bWrite && b.be[i]) mem[b.addr][8*i +: 8] <= b.wdata[8*i +: 8];
          if (aWrite && a.be[i]) mem[a.addr][8*i +: 8] <= a.wdata[8*i +: 8];
        end
      end
    end
  end

  // Write-first mode forwards the other port's enabled bytes into the read word.
  always_comb begin
    aRdata_d = mem[a.addr];
    bRdata_d = mem[b.addr];
    if (RDW_MODE == 1 && sameAddr) begin
      for (int i = 0; i < NB; i++) begin
        if (bWrite && b.be[i]) aRdata_d[8*i +: 8] = b.wdata[8*i +: 8];
        if (aWrite && a.be[i]) bRdata_d[8*i +: 8] = a.wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aRdata_q  <= '0;
      bRdata_q  <= '0;
      aRvalid_q <= 1'b0;
      bRvalid_q <= 1'b0;
    end else begin
      aRvalid_q <= aRead;
      bRvalid_q <= bRead;
      if (aRead) aRdata_q <= aRdata_d;
      if (bRead) bRdata_q <= bRdata_d;
    end
  end

  assign a.rdata  = aRdata_q;
  assign a.rvalid = aRvalid_q;
  assign b.rdata  = bRdata_q;
  assign b.rvalid = bRvalid_q;
  assign busy     = (rst && (CLEAR_ON_RST != 0)) || (state_q == CLEAR);
endmodule

// File: tb/tb_dp_ram_be.sv
// Directed bench for dp_ram_be: one read-first and one write-first instance share stimulus.
module tb_dp_ram_be;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy0, busy1;
  int   errors = 0;
  int   checks = 0;
  int   n;
  logic seen;

  dp_ram_be_if #(.DATA_W(16), .ADDR_W(8)) ifA0 ();
  dp_ram_be_if #(.DATA_W(16), .ADDR_W(8)) ifB0 ();
  dp_ram_be_if #(.DATA_W(16), .ADDR_W(8)) ifA1 ();
  dp_ram_be_if #(.DATA_W(16), .ADDR_W(8)) ifB1 ();

  assign ifA1.en = ifA0.en;  assign ifA1.we = ifA0.we;  assign ifA1.be = ifA0.be;
  assign ifA1.addr = ifA0.addr;  assign ifA1.wdata = ifA0.wdata;
  assign ifB1.en = ifB0.en;  assign ifB1.we = ifB0.we;  assign ifB1.be = ifB0.be;
  assign ifB1.addr = ifB0.addr;  assign ifB1.wdata = ifB0.wdata;

  dp_ram_be #(.DATA_W(16), .ADDR_W(8), .RDW_MODE(0), .CLEAR_ON_RST(1)) dut0 (
    .clk(clk), .rst(rst), .a(ifA0.slave), .b(ifB0.slave), .busy(busy0));
  dp_ram_be #(.DATA_W(16), .ADDR_W(8), .RDW_MODE(1), .CLEAR_ON_RST(1)) dut1 (
    .clk(clk), .rst(rst), .a(ifA1.slave), .b(ifB1.slave), .busy(busy1));

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic setInputs(input logic aEn, input logic aWe, input logic [1:0] aBe,
                           input logic [7:0] aAddr, input logic [15:0] aWd,
                           input logic bEn, input logic bWe, input logic [1:0] bBe,
                           input logic [7:0] bAddr, input logic [15:0] bWd);
    ifA0.en = aEn; ifA0.we = aWe; ifA0.be = aBe; ifA0.addr = aAddr; ifA0.wdata = aWd;
    ifB0.en = bEn; ifB0.we = bWe; ifB0.be = bBe; ifB0.addr = bAddr; ifB0.wdata = bWd;
  endtask

  // One clock with the given requests; outputs are sampled 1 ns after the edge.
  task automatic applyStimulus(input logic aEn, input logic aWe, input logic [1:0] aBe,
                               input logic [7:0] aAddr, input logic [15:0] aWd,
                               input logic bEn, input logic bWe, input logic [1:0] bBe,
                               input logic [7:0] bAddr, input logic [15:0] bWd);
    setInputs(aEn, aWe, aBe, aAddr, aWd, bEn, bWe, bBe, bAddr, bWd);
    @(posedge clk); #1;
    setInputs(0, 0, 2'b00, 8'h00, 16'h0000, 0, 0, 2'b00, 8'h00, 16'h0000);
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 2'b00, 8'h00, 16'h0000, 0, 0, 2'b00, 8'h00, 16'h0000);
  endtask

  // Counts edges until busy falls, bounded; also records any rvalid seen meanwhile.
  task automatic waitClear(output int cnt, output logic anyValid);
    cnt = 0;
    anyValid = 1'b0;
    while (busy0 && cnt < 1000) begin
      @(posedge clk); #1;
      cnt++;
      if (ifA0.rvalid || ifB0.rvalid || ifA1.rvalid || ifB1.rvalid) anyValid = 1'b1;
    end
    setInputs(0, 0, 2'b00, 8'h00, 16'h0000, 0, 0, 2'b00, 8'h00, 16'h0000);
  endtask

  initial begin
    setInputs(0, 0, 2'b00, 8'h00, 16'h0000, 0, 0, 2'b00, 8'h00, 16'h0000);
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checkOutput("rstBusy", busy0, 1);
    checkOutput("rstArvalid", ifA0.rvalid, 0);
    checkOutput("rstBrvalid", ifB0.rvalid, 0);
    checkOutput("rstArdata", ifA0.rdata, 16'h0000);
    checkOutput("rstBrdata", ifB0.rdata, 16'h0000);
    rst = 1'b0;
    waitClear(n, seen);
    checkOutput("firstClearCycles", n, 256);
    checkOutput("busy1Done", busy1, 0);

    // Prefill 0x7F, then reset and confirm the clear wipes it.
    applyStimulus(1, 1, 2'b11, 8'h7F, 16'hFFFF, 0, 0, 2'b00, 8'h00, 16'h0000);
    applyStimulus(1, 0, 2'b00, 8'h7F, 16'h0000, 0, 0, 2'b00, 8'h00, 16'h0000);
    checkOutput("prefillRead", ifA0.rdata, 16'hFFFF);
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checkOutput("rstBusy2", busy0, 1);
    checkOutput("rstRdataCleared", ifA0.rdata, 16'h0000);
    rst = 1'b0;
    waitClear(n, seen);
    checkOutput("clearCycles", n, 256);
    applyStimulus(1, 0, 2'b00, 8'h7F, 16'h0000, 0, 0, 2'b00, 8'h00, 16'h0000);
    checkOutput("clearedRead", ifA0.rdata, 16'h0000);
    checkOutput("clearedRvalid", ifA0.rvalid, 1);
    idleCycle();
    checkOutput("rvalidPulse", ifA0.rvalid, 0);

    // Write on A, read back on B.
    applyStimulus(1, 1, 2'b11, 8'h10, 16'hBEEF, 0, 0, 2'b00, 8'h00, 16'h0000);
    checkOutput("writeNoRvalid", ifA0.rvalid, 0);
    applyStimulus(0, 0, 2'b00, 8'h00, 16'h0000, 1, 0, 2'b00, 8'h10, 16'h0000);
    checkOutput("crossRead", ifB0.rdata, 16'hBEEF);
    checkOutput("crossRvalid", ifB0.rvalid, 1);
    idleCycle();
    checkOutput("rdataHold", ifB0.rdata, 16'hBEEF);
    checkOutput("rvalidLow", ifB0.rvalid, 0);

    // Byte enables on 0x20.
    applyStimulus(1, 1, 2'b11, 8'h20, 16'h1234, 0, 0, 2'b00, 8'h00, 16'h0000);
    applyStimulus(1, 1, 2'b01, 8'h20, 16'hABCD, 0, 0, 2'b00, 8'h00, 16'h0000);
    applyStimulus(1, 0, 2'b00, 8'h20, 16'h0000, 0, 0, 2'b00, 8'h00, 16'h0000);
    checkOutput("beLow", ifA0.rdata, 16'h12CD);
    applyStimulus(1, 1, 2'b10, 8'h20, 16'h5600, 0, 0, 2'b00, 8'h00, 16'h0000);
    applyStimulus(1, 0, 2'b00, 8'h20, 16'h0000, 0, 0, 2'b00, 8'h00, 16'h0000);
    checkOutput("beHigh", ifA0.rdata, 16'h56CD);
    applyStimulus(1, 1, 2'b00, 8'h20, 16'hFFFF, 0, 0, 2'b00, 8'h00, 16'h0000);
    applyStimulus(1, 0, 2'b00, 8'h20, 16'h0000, 1, 0, 2'b00, 8'h20, 16'h0000);
    checkOutput("beNoneA", ifA0.rdata, 16'h56CD);
    checkOutput("bothReadB", ifB0.rdata, 16'h56CD);

    // Dual write collision at 0x30.
    applyStimulus(1, 1, 2'b11, 8'h30, 16'hAAAA, 1, 1, 2'b11, 8'h30, 16'h5555);
    applyStimulus(1, 0, 2'b00, 8'h30, 16'h0000, 0, 0, 2'b00, 8'h00, 16'h0000);
    checkOutput("collideFull", ifA0.rdata, 16'hAAAA);
    applyStimulus(1, 1, 2'b10, 8'h30, 16'hAAAA, 1, 1, 2'b11, 8'h30, 16'h5555);
    applyStimulus(0, 0, 2'b00, 8'h00, 16'h0000, 1, 0, 2'b00, 8'h30, 16'h0000);
    checkOutput("collideSplit", ifB0.rdata, 16'hAA55);
    checkOutput("collideSplit1", ifB1.rdata, 16'hAA55);

    // Read-during-write across ports.
    applyStimulus(1, 1, 2'b11, 8'h40, 16'h1111, 0, 0, 2'b00, 8'h00, 16'h0000);
    applyStimulus(1, 1, 2'b11, 8'h40, 16'h2222, 1, 0, 2'b00, 8'h40, 16'h0000);
    checkOutput("rdwOld", ifB0.rdata, 16'h1111);
    checkOutput("rdwNew", ifB1.rdata, 16'h2222);
    checkOutput("rdwWriterNoRvalid", ifA0.rvalid, 0);
    applyStimulus(1, 0, 2'b00, 8'h40, 16'h0000, 0, 0, 2'b00, 8'h00, 16'h0000);
    checkOutput("rdwAfter0", ifA0.rdata, 16'h2222);
    checkOutput("rdwAfter1", ifA1.rdata, 16'h2222);
    applyStimulus(1, 0, 2'b00, 8'h40, 16'h0000, 1, 1, 2'b01, 8'h40, 16'h0033);
    checkOutput("rdwBwOld", ifA0.rdata, 16'h2222);
    checkOutput("rdwBwMerged", ifA1.rdata, 16'h2233);

    // Different addresses in the same cycle.
    applyStimulus(1, 1, 2'b11, 8'h50, 16'h1357, 1, 1, 2'b11, 8'h51, 16'h2468);
    applyStimulus(1, 0, 2'b00, 8'h51, 16'h0000, 1, 0, 2'b00, 8'h50, 16'h0000);
    checkOutput("indepA", ifA0.rdata, 16'h2468);
    checkOutput("indepB", ifB0.rdata, 16'h1357);

    // Reset in the middle of a clear, with requests issued while busy.
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    while (busy0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("midClearBusy", busy0, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midRstBusy", busy0, 1);
    rst = 1'b0;
    setInputs(1, 1, 2'b11, 8'h05, 16'hFFFF, 1, 0, 2'b00, 8'h05, 16'h0000);
    waitClear(n, seen);
    checkOutput("restartCycles", n, 256);
    checkOutput("noRvalidBusy", seen, 0);
    applyStimulus(1, 0, 2'b00, 8'h05, 16'h0000, 1, 0, 2'b00, 8'h50, 16'h0000);
    checkOutput("busyWriteIgnored", ifA0.rdata, 16'h0000);
    checkOutput("clearedAfterRestart", ifB0.rdata, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
